fft_controller: RTL

FFT_CONTROLLER -- requirements
Module: fft_controller

---
 rtl/fft_controller_if.sv | 43 ++++
 rtl/fft_controller.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/fft_controller_if.sv
// -----------------------------------------------------------------------------
// fft_controller_if
// Bundles the control/handshake and sample-memory addressing signals of the
// FFT sequencer.
//   start        : request one full FFT pass (driven by the host)
//   busy         : controller is not idle
//   done         : one-cycle completion pulse
//   mem_rd_en    : sample-memory read strobe (data returns one cycle later)
//   mem_wr_en    : sample-memory write strobe for both butterfly outputs
//   addr_a/b     : butterfly input/output addresses
//   twiddle_idx  : twiddle ROM index k for W_N^k
//   res_latch    : capture enable for the butterfly result register
//   stage        : current FFT stage number
// Modports: master = controller side, slave = host/datapath side.
// -----------------------------------------------------------------------------
interface fft_controller_if #(
    parameter int LOG2N = 4
);
    localparam int STW = $clog2(LOG2N) + 1;

    logic             start;
    logic             busy;
    logic             done;
    logic             mem_rd_en;
    logic             mem_wr_en;
    logic [LOG2N-1:0] addr_a;
    logic [LOG2N-1:0] addr_b;
    logic [LOG2N-2:0] twiddle_idx;
    logic             res_latch;
    logic [STW-1:0]   stage;

    modport master (
        input  start,
        output busy, done, mem_rd_en, mem_wr_en,
        output addr_a, addr_b, twiddle_idx, res_latch, stage
    );

    modport slave (
        output start,
        input  busy, done, mem_rd_en, mem_wr_en,
        input  addr_a, addr_b, twiddle_idx, res_latch, stage
    );
endinterface

// File: rtl/fft_controller.sv
// -----------------------------------------------------------------------------
// fft_controller
// Sequences an in-place radix-2 decimation-in-time FFT of N = 2^LOG2N points
// (input already bit-reversed) through one shared combinational butterfly.
// Each butterfly takes three cycles: READ (memory read), CALC (latch the
// butterfly result), WRITE (write both results back).
// Ports:
//   clk   : clock, rising edge
//   n_rst : asynchronous active-low reset
//   bus   : fft_controller_if master modport (start in; status, strobes,
//           addresses, twiddle index and stage out)
// -----------------------------------------------------------------------------
module fft_controller #(
    parameter int LOG2N = 4
) (
    input  logic              clk,
    input  logic              n_rst,
    fft_controller_if.master  bus
);
    localparam int STW = $clog2(LOG2N) + 1;
    localparam int BW  = LOG2N - 1;

    localparam logic [STW-1:0] S_LAST = STW'(LOG2N - 1);
    localparam logic [BW-1:0]  B_LAST = '1;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        CALC,
        WRITE,
        DONE
    } state_t;

    state_t           state_reg, state_next;
    logic [STW-1:0]   s_reg, s_next;
    logic [BW-1:0]    b_reg, b_next;
    logic [LOG2N-1:0] addr_a_reg, addr_a_next;
    logic [LOG2N-1:0] addr_b_reg, addr_b_next;
    logic [BW-1:0]    tw_reg, tw_next;

    // addr_a = group*2*span + pos with span = 2^s. Since pos < span this is
    // the group bits shifted up by one extra position, OR-ed with pos.
    function automatic logic [LOG2N-1:0] calc_addr_a(input logic [STW-1:0] s,
                                                     input logic [BW-1:0]  b);
        logic [LOG2N-1:0] be;
        logic [LOG2N-1:0] mask;
        logic [LOG2N-1:0] grp;
        be   = {1'b0, b};
        mask = (LOG2N'(1) << s) - LOG2N'(1);
        grp  = be >> s;
        return (grp << (s + STW'(1))) | (be & mask);
    endfunction

    // twiddle = pos * 2^(LOG2N-1-s). In the last stage (s = LOG2N-1) the
    // shifted one falls off the BW-bit word, so the mask becomes all ones.
    function automatic logic [BW-1:0] calc_twiddle(input logic [STW-1:0] s,
                                                   input logic [BW-1:0]  b);
        logic [BW-1:0] mask;
        mask = (BW'(1) << s) - BW'(1);
        return (b & mask) << (S_LAST - s);
    endfunction

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_reg  <= IDLE;
            s_reg      <= '0;
            b_reg      <= '0;
            addr_a_reg <= '0;
            addr_b_reg <= '0;
            tw_reg     <= '0;
        end else begin
            state_reg  <= state_next;
            s_reg      <= s_next;
            b_reg      <= b_next;
            addr_a_reg <= addr_a_next;
            addr_b_reg <= addr_b_next;
            tw_reg     <= tw_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        s_next      = s_reg;
        b_next      = b_reg;
        addr_a_next = addr_a_reg;
        addr_b_next = addr_b_reg;
        tw_next     = tw_reg;

        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    state_next = READ;
                    s_next     = '0;
                    b_next     = '0;
                end
            end
            READ:  state_next = CALC;
            CALC:  state_next = WRITE;
            WRITE: begin
                if (b_reg == B_LAST && s_reg == S_LAST) begin
                    state_next = DONE;
                end else begin
                    state_next = READ;
                    if (b_reg == B_LAST) begin
                        b_next = '0;
                        s_next = s_reg + STW'(1);
                    end else begin
                        b_next = b_reg + BW'(1);
                    end
                end
            end
            DONE: begin
                state_next  = IDLE;
                s_next      = '0;
                b_next      = '0;
                addr_a_next = '0;
                addr_b_next = '0;
                tw_next     = '0;
            end
            default: state_next = IDLE;
        endcase

        // Addresses are loaded only when a new butterfly begins, so they stay
        // frozen across its READ, CALC and WRITE cycles.
        if (state_next == READ) begin
            addr_a_next = calc_addr_a(s_next, b_next);
            addr_b_next = calc_addr_a(s_next, b_next) + (LOG2N'(1) << s_next);
            tw_next     = calc_twiddle(s_next, b_next);
        end
    end

    // All outputs come from registers or state decode; start never reaches
    // an output combinationally.
    assign bus.busy        = (state_reg != IDLE);
    assign bus.done        = (state_reg == DONE);
    assign bus.mem_rd_en   = (state_reg == READ);
    assign bus.res_latch   = (state_reg == CALC);
    assign bus.mem_wr_en   = (state_reg == WRITE);
    assign bus.addr_a      = addr_a_reg;
    assign bus.addr_b      = addr_b_reg;
    assign bus.twiddle_idx = tw_reg;
    assign bus.stage       = s_reg;
endmodule
